// File: rtl/li_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : li_pkg
//  Description : Shared definitions for latency-insensitive link blocks:
//                occupancy-width helper and relay status aggregate.
//  Revision    : 1.0 - initial release
// ============================================================================
package li_pkg;

    // Width of status fields when several relay stations are aggregated.
    localparam int c_LI_STAT_W = 8;

    // Bits needed to count 0..depth inclusive.
    function automatic int li_occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Occupancy and high-water mark of one relay station.
    typedef struct packed {
        logic [c_LI_STAT_W-1:0] occupancy;
        logic [c_LI_STAT_W-1:0] high_water;
    } li_relay_status_t;

endpackage
`default_nettype wire

// File: rtl/li_link.sv
`default_nettype none
// ============================================================================
//  Module      : li_link
//  Description : Latency-insensitive link: data/valid forward, stop backward.
//  Revision    : 1.0 - initial release
// ============================================================================
interface li_link #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             stop;

    modport source (output data, output valid, input stop);
    modport sink   (input data, input valid, output stop);
endinterface
`default_nettype wire

// File: rtl/li_relay_ring.sv
`default_nettype none
// ============================================================================
//  Module      : li_relay_ring
//  Description : Circular buffer holding packets queued behind the relay
//                head register. Read data is combinational and feeds only
//                the head register. Caller never writes when full nor reads
//                when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module li_relay_ring #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and fill-count bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (rd_en) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (wr_en && !rd_en) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/li_relay_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : li_relay_fifo
//  Description : Latency-insensitive relay station with DEPTH packets of
//                buffering (head register + ring). All link outputs come
//                from flops; void packets are dropped; occupancy and a
//                clearable high-water mark are exported.
//  Revision    : 1.0 - initial release
// ============================================================================
module li_relay_fifo
    import li_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int OCC_W = li_occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    li_link.sink             in_link,
    li_link.source           out_link,
    input  logic             hwm_clear,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] high_water
);

    localparam logic [OCC_W-1:0] c_FULL = OCC_W'(DEPTH);

    logic [WIDTH-1:0] r_head_data;
    logic             r_head_valid;
    logic             r_stop;
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] r_hwm;

    logic             w_push;
    logic             w_pop;
    logic             w_head_free;
    logic             w_ring_rd;
    logic             w_ring_wr;
    logic             w_head_take_in;
    logic             w_ring_empty;
    logic [WIDTH-1:0] w_ring_data;
    logic [OCC_W-1:0] w_occ_next;

    // Stop is registered, so push depends only on in_link.valid and state.
    assign w_push         = in_link.valid & ~r_stop;
    assign w_pop          = r_head_valid & ~out_link.stop;
    assign w_head_free    = ~r_head_valid | w_pop;
    assign w_ring_rd      = w_head_free & ~w_ring_empty;
    // The input bypasses the ring only when nothing older is queued.
    assign w_head_take_in = w_head_free & w_ring_empty & w_push;
    assign w_ring_wr      = w_push & ~w_head_take_in;
    assign w_occ_next     = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);

    li_relay_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH - 1)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_ring_wr),
        .wr_data (in_link.data),
        .rd_en   (w_ring_rd),
        .rd_data (w_ring_data),
        .empty   (w_ring_empty)
    );

    // Head register: refill from the ring first, else from the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_data  <= '0;
            r_head_valid <= 1'b0;
        end else if (w_ring_rd) begin
            r_head_data  <= w_ring_data;
            r_head_valid <= 1'b1;
        end else if (w_head_take_in) begin
            r_head_data  <= in_link.data;
            r_head_valid <= 1'b1;
        end else if (w_head_free) begin
            r_head_valid <= 1'b0;
        end
    end

    // Occupancy count and the upstream stop derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= '0;
            r_stop <= 1'b0;
        end else begin
            r_occ  <= w_occ_next;
            r_stop <= (w_occ_next == c_FULL);
        end
    end

    // High-water tracker; clear reloads with the new occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hwm <= '0;
        end else if (hwm_clear) begin
            r_hwm <= w_occ_next;
        end else if (w_occ_next > r_hwm) begin
            r_hwm <= w_occ_next;
        end
    end

    assign out_link.data  = r_head_data;
    assign out_link.valid = r_head_valid;
    assign in_link.stop   = r_stop;
    assign occupancy      = r_occ;
    assign high_water     = r_hwm;

endmodule
`default_nettype wire

// File: doc/li_relay_fifo.md
# li_relay_fifo

Parametrised latency-insensitive relay station with configurable buffering depth. It sits on any `li_link` segment between a source and a sink. It breaks all combinational paths: data, valid and stop are all driven from flops. It absorbs up to DEPTH packets of downstream back-pressure before stopping upstream. It also drops void packets, and exposes occupancy and a clearable high-water mark for link-sizing and debug.

## Interface
- `WIDTH`, 6, packet data width in bits (≥1).
- `DEPTH`, 4, total packet capacity including the output register (≥2; DEPTH=2 is behaviourally equivalent to the classic main+aux relay station).
- `OCC_W`, `$clog2(DEPTH+1)`, occupancy/high-water-mark width (derived; do not override).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `in_link`  `li_link.sink`  WIDTH+2  upstream link: `data`[WIDTH], `valid` in; `stop` out.
- `out_link`  `li_link.source`  WIDTH+2  downstream link: `data`[WIDTH], `valid` out; `stop` in.
- `hwm_clear`  in  1  synchronous clear of the high-water mark.
- `occupancy`  out  OCC_W  packets currently held (0..DEPTH), registered.
- `high_water`  out  OCC_W  maximum `occupancy` since reset or last `hwm_clear`.

## Operation
- Storage: one head register (drives `out_link.data`/`valid` directly) plus a (DEPTH-1)-entry circular ring holding packets queued behind the head, in arrival order.
- Push: `push = in_link.valid & ~in_link.stop`. Void packets (`valid=0`) are never stored, whatever the state of `stop`.
- Pop: `pop = out_link.valid & ~out_link.stop`.
- `out_link.valid` = (occupancy ≠ 0). When empty, `out_link.data` holds its last value and `out_link.valid` is 0. An invalid head is therefore always replaceable.
- Head update per cycle:
  - (head empty or pop) and ring non-empty: head ← ring oldest, ring read pointer advances.
  - (head empty or pop) and ring empty and push: head ← `in_link.data`.
  - Otherwise: head holds.
- Ring write: on a push not consumed by the head, the ring write pointer advances. Both ring pointers wrap modulo DEPTH-1.
- `occupancy` next = occupancy + push − pop. Push and pop in the same cycle leave it unchanged.
- `in_link.stop` = (occupancy == DEPTH). It is a function of registered state only, so there is no combinational path from `out_link.stop` or `in_link.valid`.
- Invariants:
  - No packet is lost, duplicated or reordered.
  - A push never occurs when occupancy == DEPTH.
  - A pop never occurs when occupancy == 0.
- High-water mark: `high_water` ← max(high_water, occupancy next) each cycle.
  - When `hwm_clear` is asserted, `high_water` ← occupancy next (clear has priority over the max update).

## Timing
- Latency when empty and unstalled: 1 cycle. Input valid at edge N appears on `out_link` after edge N.
- Throughput: 1 packet/cycle sustained while `out_link.stop` = 0.
- Stop assertion: `in_link.stop` rises the cycle after the edge at which occupancy reaches DEPTH. It falls the cycle after the first pop at full occupancy.
- Full with `out_link.stop` low: pop occurs and no push occurs (stop is high), so occupancy becomes DEPTH-1 and `stop` drops.
- Reset: synchronous and active-high; it takes priority over all other updates.
  - Reset values: `out_link.valid`=0, `out_link.data`=0, `in_link.stop`=0, `occupancy`=0, `high_water`=0, ring pointers 0.
  - Packets present when reset is asserted mid-operation are discarded.
  - Ring contents are not reset.

## Structure
- Shared package `li_pkg`: occupancy-width function `li_occ_w(depth)`, and a `li_relay_status_t` struct (occupancy, high_water) for status aggregation.
- Sub-module `li_relay_ring`:
  - Parameters: WIDTH, DEPTH-1.
  - Contents: circular buffer, wr/rd pointers, count, empty flag.
  - `rd_data` reads the ring entry combinationally; it feeds only the head register, never the output port.
- Top-level `li_relay_fifo` holds the head register, push/pop/occupancy logic and the high-water tracker.

## Test plan
- Empty pass-through, DEPTH=4: stream A,B,C valid with `out_link.stop`=0 → A,B,C out on consecutive cycles, 1-cycle latency, `occupancy` stays 1, `in_link.stop` never rises.
- Fill, DEPTH=4: hold `out_link.stop`=1 and send P0..P5 with valid every cycle → P0..P3 accepted; `in_link.stop`=1 from the cycle after P3; `occupancy`=4, `high_water`=4; upstream holds P4.
- Drain: release `out_link.stop` → P0,P1,P2,P3,P4,P5 emitted in order, one per cycle; `in_link.stop` falls one cycle after the first pop.
- Void drop: alternate valid/void inputs with `out_link.stop`=1 and occupancy 2 → only valid packets counted; `occupancy` increments only on valid cycles.
- Pointer wrap, DEPTH=3: random stop (50%) with 1000 sequence-numbered packets → in-order, gap-free output; scoreboard matches; `occupancy` ≤ 3 always.
- Reset and clear: assert `reset` with occupancy 3 → next cycle all outputs 0. Then reach occupancy 2, drain to 0, pulse `hwm_clear` → `high_water` 2 → 0.
